// File: rtl/mouse_tracker.sv
// mouse_tracker: assembles 3-byte PS/2 mouse packets and keeps a
// screen-clamped cursor position plus button state.
//
// Ports
//   Clk, Reset_n              clock, synchronous active-low reset
//   data_byte, data_valid     received PS/2 byte and its 1-cycle strobe
//   mouse_x, mouse_y          clamped cursor position (y=0 is top of screen)
//   leftButton, rightButton   button state from last accepted packet
//   packet_valid              1-cycle pulse after each accepted packet
//   sync_error                1-cycle pulse on bad byte 0 or inter-byte timeout
//
// Optional feature macro: MOUSE_OVF_DISCARD_EN
//   When defined, an axis whose overflow bit is set in byte 0 contributes
//   a zero delta; buttons and packet_valid still update.
module mouse_tracker #(
  parameter int SCREEN_W       = 640,
  parameter int SCREEN_H       = 480,
  parameter int X_INIT         = 320,
  parameter int Y_INIT         = 240,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] data_byte,
  input  logic       data_valid,
  output logic [9:0] mouse_x,
  output logic [9:0] mouse_y,
  output logic       leftButton,
  output logic       rightButton,
  output logic       packet_valid,
  output logic       sync_error
);

  localparam int GW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [11:0] XMAX = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] YMAX = 12'(SCREEN_H - 1);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_e;

  state_e        state_q;
  logic [GW-1:0] gap_q;
  // Only the byte-0 fields the update needs: {Ysign, Xsign, R, L}
  logic [3:0]    b0_q;
  logic [7:0]    b1_q;
`ifdef MOUSE_OVF_DISCARD_EN
  logic [1:0]    ovf_q;   // {Yovf, Xovf}
`endif

  logic signed [11:0] dx, dy, nx, ny;
  logic [9:0]         nx_d, ny_d;

  // Next position is computed from the latched b0/b1 and the live byte 2,
  // so the update lands on the byte-2 strobe edge.
  always_comb begin
    dx = {{4{b0_q[2]}}, b1_q};
    dy = {{4{b0_q[3]}}, data_byte};
`ifdef MOUSE_OVF_DISCARD_EN
    if (ovf_q[0]) dx = '0;
    if (ovf_q[1]) dy = '0;
`endif
    nx = $signed({2'b00, mouse_x}) + dx;
    ny = $signed({2'b00, mouse_y}) - dy;   // PS/2 +Y is up, screen +Y is down
    if (nx < 0)         nx_d = '0;
    else if (nx > XMAX) nx_d = XMAX[9:0];
    else                nx_d = nx[9:0];
    if (ny < 0)         ny_d = '0;
    else if (ny > YMAX) ny_d = YMAX[9:0];
    else                ny_d = ny[9:0];
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q      <= WAIT_B0;
      gap_q        <= '0;
      b0_q         <= '0;
      b1_q         <= '0;
`ifdef MOUSE_OVF_DISCARD_EN
      ovf_q        <= '0;
`endif
      mouse_x      <= 10'(X_INIT);
      mouse_y      <= 10'(Y_INIT);
      leftButton   <= 1'b0;
      rightButton  <= 1'b0;
      packet_valid <= 1'b0;
      sync_error   <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      sync_error   <= 1'b0;
      case (state_q)
        WAIT_B0: begin
          gap_q <= '0;
          if (data_valid) begin
            if (data_byte[3]) begin
              b0_q    <= {data_byte[5:4], data_byte[1:0]};
`ifdef MOUSE_OVF_DISCARD_EN
              ovf_q   <= data_byte[7:6];
`endif
              state_q <= WAIT_B1;
            end else begin
              sync_error <= 1'b1;   // byte 0 must carry bit3=1
            end
          end
        end
        WAIT_B1, WAIT_B2: begin
          // A strobe on the expiry cycle wins over the timeout.
          if (data_valid) begin
            gap_q <= '0;
            if (state_q == WAIT_B1) begin
              b1_q    <= data_byte;
              state_q <= WAIT_B2;
            end else begin
              mouse_x      <= nx_d;
              mouse_y      <= ny_d;
              leftButton   <= b0_q[0];
              rightButton  <= b0_q[1];
              packet_valid <= 1'b1;
              state_q      <= WAIT_B0;
            end
          end else if (gap_q == GAP_MAX) begin
            gap_q      <= '0;
            sync_error <= 1'b1;
            state_q    <= WAIT_B0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: begin
          gap_q   <= '0;
          state_q <= WAIT_B0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mouse_tracker.sv
// tb_mouse_tracker: directed packets followed by randomized byte traffic,
// every output compared each cycle against a packet-queue reference model.
module tb_mouse_tracker;

  localparam int T  = 40;   // short timeout keeps the run small
  localparam int W  = 640;
  localparam int H  = 480;
  localparam int XI = 320;
  localparam int YI = 240;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] data_byte = '0;
  logic       data_valid = 1'b0;
  logic [9:0] mouse_x, mouse_y;
  logic       leftButton, rightButton, packet_valid, sync_error;

  mouse_tracker #(.SCREEN_W(W), .SCREEN_H(H), .X_INIT(XI), .Y_INIT(YI),
                  .TIMEOUT_CYCLES(T)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .data_byte(data_byte), .data_valid(data_valid),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .leftButton(leftButton),
    .rightButton(rightButton), .packet_valid(packet_valid), .sync_error(sync_error)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model: bytes of the packet in progress, idle cycles since last byte
  logic [7:0] pkt[$];
  int  idle;
  int  ex, ey;
  bit  el, er, epv, ese;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    pkt.delete();
    idle = 0; ex = XI; ey = YI; el = 0; er = 0; epv = 0; ese = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] b);
    int dx, dy;
    epv = 0; ese = 0;
    if (v) begin
      idle = 0;
      if (pkt.size() == 0 && !b[3]) ese = 1;
      else pkt.push_back(b);
      if (pkt.size() == 3) begin
        dx = pkt[0][4] ? int'(pkt[1]) - 256 : int'(pkt[1]);
        dy = pkt[0][5] ? int'(pkt[2]) - 256 : int'(pkt[2]);
`ifdef MOUSE_OVF_DISCARD_EN
        if (pkt[0][6]) dx = 0;
        if (pkt[0][7]) dy = 0;
`endif
        ex = clampi(ex + dx, W - 1);
        ey = clampi(ey - dy, H - 1);
        el = pkt[0][0]; er = pkt[0][1]; epv = 1;
        pkt.delete();
      end
    end else if (pkt.size() > 0) begin
      idle++;
      if (idle == T) begin
        ese = 1; pkt.delete(); idle = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("mouse_x", mouse_x, ex);
    chk("mouse_y", mouse_y, ey);
    chk("leftButton", leftButton, el);
    chk("rightButton", rightButton, er);
    chk("packet_valid", packet_valid, epv);
    chk("sync_error", sync_error, ese);
  endtask

  task automatic cycle(input bit v, input logic [7:0] b);
    data_valid = v; data_byte = b;
    @(posedge Clk);
    model_step(v, b);
    #1;
    check_all();
    data_valid = 1'b0;
  endtask

  task automatic rst(input int n);
    Reset_n = 1'b0; data_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      model_reset();
      #1;
      check_all();
    end
    Reset_n = 1'b1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    cycle(1'b1, a); cycle(1'b0, 8'h00);
    cycle(1'b1, b); cycle(1'b1, c);
  endtask

  initial begin
    int x0;
    logic [7:0] rb;
    int sel;

    // reset state
    rst(2);
    idle_n(2);

    // basic packet: L=1, dx=+10, dy=+5
    send3(8'h09, 8'h0A, 8'h05);
    chk("t2_pv", packet_valid, 1);
    chk("t2_x", mouse_x, 330);
    chk("t2_y", mouse_y, 235);
    chk("t2_l", leftButton, 1);
    idle_n(1);

    // dx=-256, dy=-256 from centre: y clamps to bottom edge
    rst(1);
    send3(8'h38, 8'h00, 8'h00);
    chk("t3_x", mouse_x, 64);
    chk("t3_y", mouse_y, 479);

    // bad byte 0, then a good packet
    cycle(1'b1, 8'h00);
    chk("t4_err", sync_error, 1);
    send3(8'h08, 8'h01, 8'h01);
    chk("t4_x", mouse_x, 65);
    chk("t4_y", mouse_y, 478);

    // partial packet times out, then right button packet
    cycle(1'b1, 8'h08); cycle(1'b1, 8'h05);
    idle_n(T - 1);
    chk("t5_noerr_early", sync_error, 0);
    cycle(1'b0, 8'h00);
    chk("t5_timeout", sync_error, 1);
    chk("t5_x_hold", mouse_x, 65);
    send3(8'h0A, 8'h00, 8'h00);
    chk("t5_r", rightButton, 1);

    // strobe on the expiry cycle is accepted, no error
    cycle(1'b1, 8'h08);
    idle_n(T - 1);
    cycle(1'b1, 8'h03);
    chk("expiry_byte_wins", sync_error, 0);
    cycle(1'b1, 8'h00);
    chk("expiry_pv", packet_valid, 1);
    chk("expiry_x", mouse_x, 68);

    // X overflow bit set
    x0 = ex;
    send3(8'h48, 8'h10, 8'h00);
`ifdef MOUSE_OVF_DISCARD_EN
    chk("t6_x", mouse_x, x0);
`else
    chk("t6_x", mouse_x, x0 + 16);
`endif

    // push to edges: right/top, then left/bottom
    for (int i = 0; i < 4; i++) send3(8'h08, 8'hFF, 8'h7F);
    chk("edge_xmax", mouse_x, W - 1);
    chk("edge_ymin", mouse_y, 0);
    for (int i = 0; i < 4; i++) send3(8'h38, 8'h00, 8'h00);
    chk("edge_xmin", mouse_x, 0);
    chk("edge_ymax", mouse_y, H - 1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 2) begin
        rst(1);
      end else if (sel < 5) begin
        idle_n(T - 2 + $urandom_range(0, 3));
      end else begin
        rb = 8'($urandom);
        if (pkt.size() == 0 && $urandom_range(0, 7) != 0) rb[3] = 1'b1;
        cycle($urandom_range(0, 2) == 0, rb);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
